// File: rtl/cache_nway.sv
// cache_nway: N-way set-associative, write-back, write-allocate cache with
// tree pseudo-LRU replacement and saturating hit/miss counters.
// CPU side is a 32-bit word port; memory side moves one full line per transfer.
module cache_nway #(
  parameter int s_offset = 5,
  parameter int s_index  = 3,
  parameter int num_ways = 4,
  parameter int s_tag    = 32 - s_offset - s_index,
  parameter int s_line   = 8 * 2**s_offset
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       mem_address,
  output logic [31:0]       mem_rdata,
  input  logic [31:0]       mem_wdata,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [3:0]        mem_byte_enable,
  output logic              mem_resp,
  output logic              cache_hit,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count,
  output logic [31:0]       pmem_address,
  input  logic [s_line-1:0] pmem_rdata,
  output logic [s_line-1:0] pmem_wdata,
  output logic              pmem_read,
  output logic              pmem_write,
  input  logic              pmem_resp
);

  localparam int num_sets = 2**s_index;
  localparam int levels   = $clog2(num_ways);
  localparam int way_w    = (num_ways > 1) ? levels : 1;
  localparam int plru_w   = (num_ways > 1) ? num_ways - 1 : 1;
  localparam int word_w   = (s_offset > 2) ? s_offset - 2 : 1;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_e;

  // Storage arrays
  logic [num_ways-1:0] valid_q [num_sets];
  logic [num_ways-1:0] dirty_q [num_sets];
  logic [plru_w-1:0]   plru_q  [num_sets];
  logic [s_tag-1:0]    tag_q   [num_sets][num_ways];
  logic [s_line-1:0]   data_q  [num_sets][num_ways];

  // Control state
  state_e            state_q, state_d;
  logic [way_w-1:0]  victim_q;
  logic              refill_q;     // previous cycle completed a fill: next lookup is a retry
  logic [31:0]       hit_count_q, miss_count_q;

  // Request decode
  logic [s_tag-1:0]   req_tag;
  logic [s_index-1:0] req_idx;
  logic [word_w-1:0]  req_word;
  logic               req;

  assign req_tag  = mem_address[31 -: s_tag];
  assign req_idx  = mem_address[s_offset +: s_index];
  assign req_word = word_w'(mem_address[s_offset-1:0] >> 2);
  assign req      = mem_read | mem_write;

  // Walk the tree from the root following the bits to the victim leaf.
  function automatic logic [way_w-1:0] plru_victim(input logic [plru_w-1:0] bits);
    int node;
    node = 0;
    for (int l = 0; l < levels; l++) node = bits[node] ? 2*node + 2 : 2*node + 1;
    return way_w'(node - (num_ways - 1));
  endfunction

  // Point every node on the path to the accessed way away from it.
  function automatic logic [plru_w-1:0] plru_touch(input logic [plru_w-1:0] bits,
                                                    input logic [way_w-1:0]  way);
    logic [plru_w-1:0] nb;
    int                node;
    logic              dir;
    nb   = bits;
    node = 0;
    for (int l = 0; l < levels; l++) begin
      dir      = way[levels-1-l];
      nb[node] = ~dir;
      node     = 2*node + 1 + int'(dir);
    end
    return nb;
  endfunction

  // Tag lookup and victim choice (lowest invalid way, else PLRU victim)
  logic              hit, inv_found;
  logic [way_w-1:0]  hit_way, inv_way, victim_way;
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < num_ways; w++) begin
      if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = way_w'(w);
      end
    end
    for (int w = num_ways - 1; w >= 0; w--) begin
      if (!valid_q[req_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = way_w'(w);
      end
    end
    victim_way = inv_found ? inv_way : plru_victim(plru_q[req_idx]);
  end

  // Read word select and byte-merge of the write data into the hit line
  logic [s_line-1:0] hit_line, wr_line;
  always_comb begin
    hit_line  = data_q[req_idx][hit_way];
    mem_rdata = hit_line[32*req_word +: 32];
    wr_line   = hit_line;
    for (int b = 0; b < 4; b++) begin
      if (mem_byte_enable[b]) wr_line[32*req_word + 8*b +: 8] = mem_wdata[8*b +: 8];
    end
  end

  // Event strobes
  logic hit_now, miss_now, wr_hit, first_hit, wb_done, fill_done;
  assign hit_now   = (state_q == IDLE) && req && hit;
  assign miss_now  = (state_q == IDLE) && req && !hit;
  assign wr_hit    = hit_now && mem_write;
  assign first_hit = hit_now && !refill_q;
  assign wb_done   = (state_q == WRITEBACK) && pmem_resp;
  assign fill_done = (state_q == ALLOCATE) && pmem_resp;

  // Next-state and handshake outputs
  always_comb begin
    state_d      = state_q;
    mem_resp     = 1'b0;
    cache_hit    = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = {req_tag, req_idx, {s_offset{1'b0}}};
    pmem_wdata   = data_q[req_idx][victim_q];
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            mem_resp  = 1'b1;
            cache_hit = !refill_q;
          end else if (valid_q[req_idx][victim_way] && dirty_q[req_idx][victim_way]) begin
            state_d = WRITEBACK;
          end else begin
            state_d = ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q[req_idx][victim_q], req_idx, {s_offset{1'b0}}};
        if (pmem_resp) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        pmem_read = 1'b1;
        if (pmem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register, victim latch, retry flag and saturating counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      victim_q     <= '0;
      refill_q     <= 1'b0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q  <= state_d;
      refill_q <= fill_done;
      if (miss_now) victim_q <= victim_way;
      if (first_hit && (hit_count_q != '1)) hit_count_q <= hit_count_q + 32'd1;
      if (miss_now && (miss_count_q != '1)) miss_count_q <= miss_count_q + 32'd1;
    end
  end

  // Valid, dirty and PLRU bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < num_sets; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      if (hit_now) plru_q[req_idx] <= plru_touch(plru_q[req_idx], hit_way);
      if (wr_hit) dirty_q[req_idx][hit_way] <= 1'b1;
      if (wb_done) dirty_q[req_idx][victim_q] <= 1'b0;
      if (fill_done) begin
        valid_q[req_idx][victim_q] <= 1'b1;
        dirty_q[req_idx][victim_q] <= 1'b0;
      end
    end
  end

  // Tag and data arrays: hit writes merge bytes, fills replace the victim line
  // NOTE: tag/data carry no reset; valid bits gate every use, so they need none.
  always_ff @(posedge clk) begin
    if (wr_hit) data_q[req_idx][hit_way] <= wr_line;
    if (fill_done) begin
      data_q[req_idx][victim_q] <= pmem_rdata;
      tag_q[req_idx][victim_q]  <= req_tag;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule
